// File: rtl/rv32i_types.sv
// Shared RV32I types plus the line/burst geometry and the adaptor FSM states.
package rv32i_types;
  typedef logic [31:0] rv32i_word;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} pmem_adaptor_state_t;
endpackage

// File: rtl/pmem_line_buffer.sv
// One cache-line register: beat-indexed fill, whole-line load, synchronous clear.
module pmem_line_buffer #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   beat_we,
  input  logic [IDX_W-1:0]       beat_idx,
  input  logic [BURST_WIDTH-1:0] beat_wdata,
  input  logic                   load,
  input  logic [LINE_WIDTH-1:0]  line_in,
  output logic [LINE_WIDTH-1:0]  line_o
);
  logic [LINE_WIDTH-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (clr)          line_d = '0;
    else if (load)    line_d = line_in;
    else if (beat_we) line_d[beat_idx*BURST_WIDTH +: BURST_WIDTH] = beat_wdata;
  end

  always_ff @(posedge clk) line_q <= line_d;

  assign line_o = line_q;
endmodule

// File: rtl/pmem_line_adaptor.sv
// Turns one line-wide pmem read/write into a 4-beat burst on the memory bus.
module pmem_line_adaptor #(
  parameter int LINE_WIDTH  = rv32i_types::LINE_WIDTH,
  parameter int BURST_WIDTH = rv32i_types::BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  rv32i_types::rv32i_word pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output rv32i_types::rv32i_word mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp
);
  import rv32i_types::*;

  localparam int NBEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam rv32i_word LINE_MASK = ~rv32i_word'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  pmem_adaptor_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  rv32i_word           addr_q, addr_d;
  logic                rd_we, wr_load;
  logic [LINE_WIDTH-1:0] rd_line, wr_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_we   = 1'b0;
    wr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pmem_read) begin
          addr_d  = pmem_address & LINE_MASK;
          state_d = READ;
        end else if (pmem_write) begin
          addr_d  = pmem_address & LINE_MASK;
          wr_load = 1'b1;
          state_d = WRITE;
        end
      end
      READ, WRITE: begin
        if (mem_resp) begin
          rd_we = (state_q == READ);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Separate read and write lines so pmem_rdata survives intervening writes.
  pmem_line_buffer #(.LINE_WIDTH(LINE_WIDTH), .BURST_WIDTH(BURST_WIDTH), .IDX_W(CNT_W)) u_rd_buf (
    .clk(clk), .clr(rst), .beat_we(rd_we), .beat_idx(cnt_q), .beat_wdata(mem_rdata),
    .load(1'b0), .line_in('0), .line_o(rd_line)
  );

  pmem_line_buffer #(.LINE_WIDTH(LINE_WIDTH), .BURST_WIDTH(BURST_WIDTH), .IDX_W(CNT_W)) u_wr_buf (
    .clk(clk), .clr(rst), .beat_we(1'b0), .beat_idx('0), .beat_wdata('0),
    .load(wr_load), .line_in(pmem_wdata), .line_o(wr_line)
  );

  assign pmem_rdata  = rd_line;
  assign pmem_resp   = (state_q == DONE);
  assign mem_address = addr_q;
  assign mem_read    = (state_q == READ);
  assign mem_write   = (state_q == WRITE);
  assign mem_wdata   = (state_q == WRITE) ? wr_line[cnt_q*BURST_WIDTH +: BURST_WIDTH] : '0;
endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Table-driven and randomized transaction checks for pmem_line_adaptor.
module tb_pmem_line_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [63:0]  mem_wdata, mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_rdata = '0;

  pmem_line_adaptor dut (
    .clk(clk), .rst(rst), .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd, wr;
    logic [31:0]  addr, exp_addr;
    logic [255:0] wline, mline;
    logic [15:0]  pat;
    int           pat_len;
    int           lat;
    bit           b2b;
  } vec_t;

  task automatic chk(input logic [255:0] act, input logic [255:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd_line();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  // Memory-side behaviour: the bus stays requested until four beats are
  // accepted, each write beat is the line chunk for beats accepted so far,
  // and completion is reported in the cycle after the fourth acceptance.
  task automatic txn(input vec_t v, input bit rgap, input string nm);
    int nb = 0;
    int c;
    bit is_rd = v.rd;
    @(posedge clk); #2;
    pmem_read = v.rd; pmem_write = v.wr; pmem_address = v.addr; pmem_wdata = v.wline;
    mem_resp = 1'($urandom % 2); mem_rdata = rnd64();
    #2;
    chk(pmem_resp, 0, {nm, " idle resp"});
    chk(mem_read | mem_write, 0, {nm, " idle req"});
    for (c = 1; c <= 60; c++) begin
      @(posedge clk); #2;
      if (nb < 4)
        mem_resp = (c - 1 < v.pat_len) ? v.pat[c-1] : (rgap ? 1'($urandom % 2) : 1'b1);
      else
        mem_resp = 1'($urandom % 2);
      mem_rdata = (nb < 4 && mem_resp) ? v.mline[64*nb +: 64] : rnd64();
      #2;
      chk(pmem_resp, (nb == 4), {nm, " pmem_resp"});
      chk(mem_read, (is_rd && nb < 4), {nm, " mem_read"});
      chk(mem_write, (!is_rd && nb < 4), {nm, " mem_write"});
      if (nb < 4) chk(mem_address, v.exp_addr, {nm, " mem_address"});
      if (!is_rd && nb < 4) chk(mem_wdata, v.wline[64*nb +: 64], {nm, " mem_wdata"});
      if (nb == 4) begin
        if (is_rd) exp_rdata = v.mline;
        chk(pmem_rdata, exp_rdata, {nm, " pmem_rdata"});
        break;
      end
      if (mem_resp) nb++;
    end
    if (c > 60) begin
      errors++; checks++;
      $display("FAIL %s timeout: got %0d beats expected 4", nm, nb);
    end else if (v.lat >= 0) begin
      chk(c, v.lat, {nm, " latency"});
    end
  endtask

  task automatic idle(input string nm);
    @(posedge clk); #2;
    pmem_read = 0; pmem_write = 0; mem_resp = 1'($urandom % 2); mem_rdata = rnd64();
    #2;
    chk(pmem_resp, 0, {nm, " idle pmem_resp"});
    chk(mem_read | mem_write, 0, {nm, " idle bus"});
    chk(pmem_rdata, exp_rdata, {nm, " rdata stable"});
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(pmem_resp, 0, {nm, " pmem_resp"});
    chk(pmem_rdata, 0, {nm, " pmem_rdata"});
    chk(mem_read, 0, {nm, " mem_read"});
    chk(mem_write, 0, {nm, " mem_write"});
    chk(mem_address, 0, {nm, " mem_address"});
    chk(mem_wdata, 0, {nm, " mem_wdata"});
  endtask

  vec_t tbl[5];
  vec_t rv;
  logic [63:0] ba, bb, bc, bd;

  initial begin
    ba = 64'hAAAA_AAAA_AAAA_AAAA; bb = 64'hBBBB_BBBB_BBBB_BBBB;
    bc = 64'hCCCC_CCCC_CCCC_CCCC; bd = 64'hDDDD_DDDD_DDDD_DDDD;
    tbl[0] = '{1, 0, 32'h0000_1234, 32'h0000_1220, '0,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               16'h0, 0, 5, 0};
    tbl[1] = '{0, 1, 32'h8000_0047, 32'h8000_0040, {bd, bc, bb, ba}, '0,
               16'b101_1001, 7, 8, 0};
    tbl[2] = '{1, 1, 32'h0000_ABFF, 32'h0000_ABE0, rnd_line(), rnd_line(), 16'h0, 0, 5, 0};
    tbl[3] = '{1, 0, 32'h1234_5660, 32'h1234_5660, '0, rnd_line(), 16'b1_0110, 5, 7, 1};
    tbl[4] = '{0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, rnd_line(), '0, 16'h0, 0, 5, 0};

    rst = 1; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    repeat (2) @(posedge clk);
    #2; rst = 0; #2;
    chk_reset_vals("reset");

    for (int i = 0; i < 5; i++) begin
      txn(tbl[i], 0, $sformatf("vec%0d", i));
      if (!tbl[i].b2b) idle($sformatf("vec%0d", i));
    end

    // Reset after beats 0 and 1 of a read; a late beat in the reset cycle is dropped.
    @(posedge clk); #2;
    pmem_read = 1; pmem_address = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      mem_resp = 1; mem_rdata = rnd64();
      if (k == 2) rst = 1;
    end
    @(posedge clk); #2;
    rst = 0; pmem_read = 0; mem_resp = 1;
    #2;
    exp_rdata = '0;
    chk_reset_vals("midrst");
    for (int k = 0; k < 3; k++) idle("midrst");
    rv = '{1, 0, 32'h0000_4010, 32'h0000_4000, '0, rnd_line(), 16'h0, 0, 5, 0};
    txn(rv, 0, "post_rst");
    idle("post_rst");

    for (int i = 0; i < 30; i++) begin
      int r = $urandom % 3;
      rv.rd = (r != 1); rv.wr = (r != 0);
      rv.addr = $urandom; rv.exp_addr = rv.addr & 32'hFFFF_FFE0;
      rv.wline = rnd_line(); rv.mline = rnd_line();
      rv.pat = '0; rv.pat_len = 0; rv.lat = -1;
      txn(rv, 1, $sformatf("rnd%0d", i));
      if ($urandom % 2) idle($sformatf("rnd%0d", i));
    end
    idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
